// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
//   - hazard_state_e : multiply-stall FSM state (Idle = 1'b0, MultBusy = 1'b1)
//   - MULT_LAT_DEFAULT : default multiplier occupancy of EX in cycles
//   - pipe_ctrl_t / CTRL_NOP : pipeline control bundle and the all-zero NOP
//     value loaded by the ID/EX and EX/MEM bubbles
package hazard_pkg;

    typedef enum logic {
        StIdle     = 1'b0,
        StMultBusy = 1'b1
    } hazard_state_e;

    localparam int unsigned MULT_LAT_DEFAULT = 4;

    typedef struct packed {
        logic mem_2_reg;
        logic mem_write;
        logic wb;
        logic mult;
        logic alu_src;
        logic branch;
    } pipe_ctrl_t;

    // Zero controls: no writeback, no memory access, no multiply.
    localparam pipe_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mult_stall_counter.sv
// Multi-cycle multiply stall sequencer: FSM plus down-counter.
// A multiply seen in ID/EX while idle stalls for MULT_LAT-1 cycles; the
// following cycle is the final multiply cycle (no stall) before going idle.
// Ports:
//   clk, arst_n  : clock and asynchronous active-low reset
//   enable       : pipeline advance; state and counter hold when 0
//   mult_req     : ID/EX holds a multiply
//   mult_stall   : stall in progress (combinational from state and mult_req)
//   mult_final   : final multiply cycle strobe
module mult_stall_counter
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic arst_n,
    input  logic enable,
    input  logic mult_req,
    output logic mult_stall,
    output logic mult_final
);

    // Count of remaining stall cycles after the first one.
    localparam logic [CNT_W-1:0] CntLoad = (MULT_LAT > 1) ? CNT_W'(MULT_LAT - 2) : '0;
    localparam bit MultStalls = (MULT_LAT > 1);

    hazard_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mult_stall = 1'b0;
        mult_final = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mult_req && MultStalls) begin
                    mult_stall = 1'b1;
                    if (enable) begin
                        state_d = StMultBusy;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StMultBusy: begin
                if (cnt_q != '0) begin
                    mult_stall = 1'b1;
                    if (enable) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    // The multiply is still in ID/EX here; returning to idle
                    // without looking at mult_req prevents a re-trigger.
                    mult_final = 1'b1;
                    if (enable) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller for the 5-stage pipeline with a multi-cycle
// multiplier in EX. Resolves load-use (1-cycle hold of ID) and multiply
// occupancy (MULT_LAT-1 cycle hold of IF/ID/EX with EX/MEM bubbles); the
// forwarding unit downstream supplies operands once the stall clears.
// Optional macro HAZARD_STATS_EN adds saturating 16-bit stall counters.
// Ports:
//   clk, arst_n       : clock, asynchronous active-low reset
//   enable            : pipeline advance enable
//   mem_2_reg__ID_EX, WB__ID_EX, mult__ID_EX, RD__ID_EX : ID/EX instruction info
//   RS1__IF_ID, RS2__IF_ID : source registers of the instruction in ID
//   pc_write, IF_ID_write, ID_EX_write : register write enables
//   ID_EX_bubble, EX_MEM_bubble        : load NOP into that pipeline register
//   mult_busy                          : multiply stall in progress
//   lu_stalls, mult_stalls             : stall counters (HAZARD_STATS_EN only)
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       enable,
    input  logic       mem_2_reg__ID_EX,
    input  logic       WB__ID_EX,
    input  logic       mult__ID_EX,
    input  logic [4:0] RD__ID_EX,
    input  logic [4:0] RS1__IF_ID,
    input  logic [4:0] RS2__IF_ID,
    output logic       pc_write,
    output logic       IF_ID_write,
    output logic       ID_EX_write,
    output logic       ID_EX_bubble,
    output logic       EX_MEM_bubble,
    output logic       mult_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] lu_stalls,
    output logic [15:0] mult_stalls
`endif
);

    logic lu;
    logic mult_stall;
    logic mult_final;

    mult_stall_counter #(
        .MULT_LAT (MULT_LAT),
        .CNT_W    (CNT_W)
    ) u_mult_stall_counter (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .mult_req   (mult__ID_EX),
        .mult_stall (mult_stall),
        .mult_final (mult_final)
    );

    // x0 is never a real destination, so it cannot create a dependency.
    always_comb begin
        lu = mem_2_reg__ID_EX && WB__ID_EX && (RD__ID_EX != 5'd0) &&
             ((RD__ID_EX == RS1__IF_ID) || (RD__ID_EX == RS2__IF_ID));
    end

    // Multiply stall dominates; a load-use bubble is suppressed under it.
    always_comb begin
        pc_write      = !(mult_stall || lu);
        IF_ID_write   = !(mult_stall || lu);
        ID_EX_write   = !mult_stall;
        ID_EX_bubble  = lu && !mult_stall;
        // On the final cycle the product is let through into EX/MEM.
        EX_MEM_bubble = mult_stall && !mult_final;
        mult_busy     = mult_stall;
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] lu_stalls_q;
    logic [15:0] mult_stalls_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lu_stalls_q   <= '0;
            mult_stalls_q <= '0;
        end else if (enable) begin
            if (lu && (lu_stalls_q != 16'hFFFF)) begin
                lu_stalls_q <= lu_stalls_q + 16'd1;
            end
            if (mult_stall && (mult_stalls_q != 16'hFFFF)) begin
                mult_stalls_q <= mult_stalls_q + 16'd1;
            end
        end
    end

    assign lu_stalls   = lu_stalls_q;
    assign mult_stalls = mult_stalls_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit with a behavioural model:
// a multiply is tracked by its age in enabled cycles (0..MULT_LAT-1), stalling
// for ages below MULT_LAT-1; load-use is evaluated directly from the rule.
module tb_hazard_detection_unit;

    localparam int unsigned L = 4;

    logic       clk;
    logic       arst_n;
    logic       enable;
    logic       m2r, wb, mult;
    logic [4:0] rd, rs1, rs2;
    logic       pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, mult_busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] lu_stalls, mult_stalls;
`endif

    int errors = 0;
    int checks = 0;

    // Model state: age of the multiply in flight, -1 when none.
    int age = -1;
    int m_lu_cnt = 0;
    int m_mult_cnt = 0;

    hazard_detection_unit #(
        .MULT_LAT (L),
        .CNT_W    (4)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .enable           (enable),
        .mem_2_reg__ID_EX (m2r),
        .WB__ID_EX        (wb),
        .mult__ID_EX      (mult),
        .RD__ID_EX        (rd),
        .RS1__IF_ID       (rs1),
        .RS2__IF_ID       (rs2),
        .pc_write         (pc_write),
        .IF_ID_write      (if_id_write),
        .ID_EX_write      (id_ex_write),
        .ID_EX_bubble     (id_ex_bubble),
        .EX_MEM_bubble    (ex_mem_bubble),
        .mult_busy        (mult_busy)
`ifdef HAZARD_STATS_EN
        ,
        .lu_stalls        (lu_stalls),
        .mult_stalls      (mult_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_lu();
        return m2r && wb && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic logic model_stall();
        if (age >= 0) return (age < int'(L) - 1);
        return mult && (L > 1);
    endfunction

    // {pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble, EX_MEM_bubble, mult_busy}
    function automatic logic [5:0] model_out();
        logic s, u;
        s = model_stall();
        u = model_lu();
        return {!(s || u), !(s || u), !s, u && !s, s, s};
    endfunction

    function automatic logic [5:0] dut_out();
        return {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, mult_busy};
    endfunction

    task automatic set_in(input logic en, input logic m, input logic w, input logic mu,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        @(negedge clk);
        enable = en; m2r = m; wb = w; mult = mu; rd = d; rs1 = s1; rs2 = s2;
        #1;
    endtask

    // Advance the model across one rising edge using the inputs applied to it.
    task automatic tick();
        logic s, u;
        s = model_stall();
        u = model_lu();
        @(posedge clk);
        if (arst_n && enable) begin
            if (u && m_lu_cnt < 65535) m_lu_cnt++;
            if (s && m_mult_cnt < 65535) m_mult_cnt++;
            if (age < 0) begin
                if (mult && L > 1) age = 1;
            end else if (age == int'(L) - 1) begin
                age = -1;
            end else begin
                age++;
            end
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0; enable = 1'b0; m2r = 0; wb = 0; mult = 0; rd = 0; rs1 = 0; rs2 = 0;
        age = -1; m_lu_cnt = 0; m_mult_cnt = 0;
        #3;
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", dut_out(), 6'b111000);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_load_use();
        // lw x5 in ID/EX, add x6,x5,x1 in ID
        set_in(1, 1, 1, 0, 5'd5, 5'd5, 5'd1);
        checks++;
        if (dut_out() !== 6'b001100) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected %b", dut_out(), 6'b001100);
        end
        tick();
        // Load has moved to EX/MEM; the add now sees a non-load ahead of it.
        set_in(1, 0, 1, 0, 5'd6, 5'd5, 5'd1);
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL load_use_release: got %b expected %b", dut_out(), 6'b111000);
        end
        tick();
        // Match on rs2 only
        set_in(1, 1, 1, 0, 5'd9, 5'd2, 5'd9);
        checks++;
        if (dut_out() !== 6'b001100) begin
            errors++;
            $display("FAIL load_use_rs2: got %b expected %b", dut_out(), 6'b001100);
        end
        tick();
    endtask

    task automatic test_load_x0();
        set_in(1, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL load_x0_no_stall: got %b expected %b", dut_out(), 6'b111000);
        end
        tick();
        // Load without writeback cannot create a dependency.
        set_in(1, 1, 0, 0, 5'd7, 5'd7, 5'd7);
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL load_no_wb: got %b expected %b", dut_out(), 6'b111000);
        end
        tick();
    endtask

    task automatic test_mult();
        int stalls = 0;
        for (int c = 0; c < int'(L); c++) begin
            set_in(1, 0, 1, 1, 5'd3, 5'd1, 5'd2);
            if (mult_busy) stalls++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL mult_cycle%0d: got %b expected %b", c, dut_out(), model_out());
            end
            tick();
        end
        checks++;
        if (stalls != int'(L) - 1) begin
            errors++;
            $display("FAIL mult_stall_count: got %0d expected %0d", stalls, L - 1);
        end
        // Instruction after the multiply flows freely: FSM is idle again.
        set_in(1, 0, 1, 0, 5'd4, 5'd3, 5'd3);
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL mult_back_idle: got %b expected %b", dut_out(), 6'b111000);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pattern = 8'b0;
        // Expected: L-1 stalls, one free cycle, repeated.
        logic [7:0] want = 8'b0;
        for (int c = 0; c < 2 * int'(L); c++) want[c] = ((c % int'(L)) != int'(L) - 1);
        for (int c = 0; c < 2 * int'(L); c++) begin
            set_in(1, 0, 1, 1, 5'd3, 5'd1, 5'd2);
            pattern[c] = mult_busy;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %b expected %b", c, dut_out(), model_out());
            end
            tick();
        end
        checks++;
        if (pattern !== want) begin
            errors++;
            $display("FAIL b2b_pattern: got %b expected %b", pattern, want);
        end
        set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_enable_hold();
        int en_stalls = 0;
        logic en_seq [6] = '{1, 1, 0, 0, 1, 1};
        for (int c = 0; c < 6; c++) begin
            set_in(en_seq[c], 0, 1, 1, 5'd3, 5'd1, 5'd2);
            if (mult_busy && en_seq[c]) en_stalls++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL enable_hold_cycle%0d: got %b expected %b", c, dut_out(),
                         model_out());
            end
            tick();
        end
        checks++;
        if (en_stalls != int'(L) - 1) begin
            errors++;
            $display("FAIL enable_hold_total: got %0d expected %0d", en_stalls, L - 1);
        end
        set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL enable_hold_idle: got %b expected %b", dut_out(), 6'b111000);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        set_in(1, 1, 1, 1, 5'd8, 5'd8, 5'd0);
        checks++;
        if (dut_out() !== 6'b000011) begin
            errors++;
            $display("FAIL lu_mult_priority: got %b expected %b", dut_out(), 6'b000011);
        end
        tick();
        // Let the multiply run out with no load-use flags.
        for (int c = 1; c < int'(L); c++) begin
            set_in(1, 0, 0, 1, 5'd8, 5'd0, 5'd0);
            tick();
        end
    endtask

    task automatic test_reset_mid_mult();
        set_in(1, 0, 1, 1, 5'd3, 5'd1, 5'd2);
        tick();
        // Second stall cycle
        set_in(1, 0, 1, 1, 5'd3, 5'd1, 5'd2);
        checks++;
        if (mult_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_mult_busy: got %b expected 1", mult_busy);
        end
        #1;
        arst_n = 1'b0;
        mult = 1'b0;
        age = -1; m_lu_cnt = 0; m_mult_cnt = 0;
        #1;
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL async_reset_release: got %b expected %b", dut_out(), 6'b111000);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (lu_stalls !== 16'd0 || mult_stalls !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d/%0d expected 0/0", lu_stalls, mult_stalls);
        end
`endif
        @(negedge clk);
        arst_n = 1'b1;
        set_in(1, 0, 1, 0, 5'd3, 5'd1, 5'd2);
        checks++;
        if (dut_out() !== 6'b111000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected %b", dut_out(), 6'b111000);
        end
        tick();
`ifdef HAZARD_STATS_EN
        for (int c = 0; c < int'(L); c++) begin
            set_in(1, 0, 1, 1, 5'd3, 5'd1, 5'd2);
            tick();
        end
        set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (mult_stalls !== 16'(L - 1)) begin
            errors++;
            $display("FAIL stats_one_mult: got %0d expected %0d", mult_stalls, L - 1);
        end
        tick();
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 9) < 8), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b (age %0d)", c, dut_out(),
                         model_out(), age);
            end
`ifdef HAZARD_STATS_EN
            checks++;
            if (lu_stalls !== 16'(m_lu_cnt) || mult_stalls !== 16'(m_mult_cnt)) begin
                errors++;
                $display("FAIL random_stats%0d: got %0d/%0d expected %0d/%0d", c, lu_stalls,
                         mult_stalls, m_lu_cnt, m_mult_cnt);
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_x0();
        test_mult();
        test_back_to_back();
        test_enable_hold();
        test_simultaneous();
        test_reset_mid_mult();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
